// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core. Sequences one instruction at a
// time through FETCH/DECODE/execute/writeback and decodes every datapath
// select and enable from the current state. Memory states wait on MemReady
// and abort back to FETCH after TIMEOUT consecutive stalled cycles.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic       MemErr,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // A zero-width counter is not legal, so TIMEOUT=0 keeps a 1-bit stub.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            in_wait;
  logic            timeout;
  logic            op_legal;

  assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign op_legal = (Opcode == OP_RTYPE) || (Opcode == OP_LW) || (Opcode == OP_SW) ||
                    (Opcode == OP_BEQ)   || (Opcode == OP_J)  || (Opcode == OP_ADDI);
  // A same-cycle MemReady always wins over the timeout.
  assign timeout  = (TIMEOUT > 0) && in_wait && !MemReady &&
                    (int'(wait_cnt_q) == TIMEOUT - 1);
  assign State    = state_q;

  // State and stall-counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state selection.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : (timeout ? S_FETCH : S_FETCH);
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = MemReady ? S_MEMWB : (timeout ? S_FETCH : S_MEMRD);
      S_MEMWR:  state_d = MemReady ? S_FETCH : (timeout ? S_FETCH : S_MEMWR);
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Stall counter: counts consecutive MemReady=0 cycles in a wait state,
  // saturating; any completion, timeout or non-wait state clears it.
  always_comb begin
    wait_cnt_d = '0;
    if (in_wait && !MemReady && !timeout) begin
      wait_cnt_d = (wait_cnt_q == {CW{1'b1}}) ? wait_cnt_q : wait_cnt_q + CW'(1);
    end
  end

  // Datapath control decode from the current state.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'd0;
    Illegal  = 1'b0;
    MemErr   = timeout;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Illegal = !op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'd1;
        PCWrite  = Zero;
      end
      S_JUMP: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS core. It sequences one instruction at a time and drives every datapath select:
- 2:1 Mux selects: IorD, RegDst, MemToReg, ALUSrcA.
- 3:1 MuxJ select: PCSource.
- Plus ALUSrcB, ALUOp, register-file, IR, PC and memory enables.

Memory accesses use a MemReady handshake with a bounded-wait timeout.

Parameters:
TIMEOUT, 16, max consecutive cycles without MemReady in a memory state before abort; 0 disables the timeout.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Opcode  input  6  IR[31:26], stable from DECODE onward
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the access this cycle
PCWrite  output  1  PC load enable (already qualified by Zero for beq)
IorD  output  1  memory address mux: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
RegDst  output  1  0=rt, 1=rd
MemToReg  output  1  0=ALUOut, 1=MDR
RegWrite  output  1  register-file write enable
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct
PCSource  output  2  MuxJ select: 0=ALU result, 1=ALUOut, 2=jump target
Illegal  output  1  one-cycle pulse on an unsupported opcode
MemErr  output  1  one-cycle pulse on a memory timeout
State  output  4  current state encoding (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 are unreachable and go to FETCH.
- Reset: at any clock edge where Reset=1, State becomes FETCH and WaitCnt becomes 0, whatever operation is in progress. No other state is kept.
- Outputs are decoded combinationally from State. Only the following are also gated by inputs: PCWrite/IRWrite in FETCH and BRANCH, Illegal, MemErr.
- Any output not listed for a state is 0.
- Per-state outputs, one state per line:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0, IRWrite=PCWrite=MemReady.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR / ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, RegDst=0, MemToReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegWrite=1, RegDst=1, MemToReg=0.
  - ADDIWB: RegWrite=1, RegDst=0, MemToReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=Zero.
  - JUMP: PCSource=2, PCWrite=1.
- Transitions, one state per line:
  - FETCH->DECODE when MemReady=1.
  - DECODE branches on Opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX. Any other opcode: Illegal=1 in the DECODE cycle, then FETCH.
  - MEMADR->MEMRD for lw, MEMWR for sw (Opcode re-checked).
  - MEMRD->MEMWB when MemReady=1.
  - MEMWR->FETCH when MemReady=1.
  - EXEC->ALUWB, ADDIEX->ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Wait states are FETCH, MEMRD and MEMWR; each holds while MemReady=0.
- WaitCnt: clears on entering a wait state and on MemReady=1; increments each wait cycle with MemReady=0.
- Timeout:
  - Trigger: TIMEOUT>0, MemReady=0, WaitCnt==TIMEOUT-1.
  - Effect: MemErr=1 that cycle, next state FETCH, PCWrite/IRWrite/RegWrite stay 0, so the PC is not advanced.
  - If MemReady=1 in that same cycle, MemReady wins and there is no error.
- WaitCnt width is clog2(TIMEOUT+1) and it saturates. With TIMEOUT=0 it never triggers.
- Cycle counts with zero memory wait: R-type/addi/sw 4, lw 5, beq/j 3.

Test Plan:
1. Reset for 2 cycles, then R-type (Opcode=0), MemReady=1 -> State 0,1,6,7,0; RegDst=1 and RegWrite=1 in ALUWB; PCWrite=1 only in FETCH.
2. lw (100011) with MemReady low 3 cycles in MEMRD -> State holds 3 for 4 cycles; MemWB cycle has MemToReg=1; total 8 cycles FETCH-to-FETCH.
3. beq (000100) with Zero=0, then Zero=1 -> PCSource=1 in BRANCH both times; PCWrite=0 then 1.
4. j (000010) -> JUMP cycle has PCSource=2, PCWrite=1; returns to FETCH after 3 cycles total.
5. TIMEOUT=4, MemReady held 0 in FETCH -> MemErr pulses on the 4th wait cycle, State returns to 0, IRWrite never 1. Repeat with MemReady=1 on the 4th cycle -> no MemErr, State=1.
6. Opcode=111111 in DECODE -> Illegal=1 one cycle, then FETCH. Separately, Reset asserted in MEMRD -> next State=0, no RegWrite.
